// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer_pkg
//  Purpose  : Shared definitions for the store buffer: funct3 encodings, the
//             queued-entry layout and the byte-lane alignment helpers used for
//             both store alignment and load overlap masks.
//  Contents : F3_* funct3 constants, sb_entry_t, lane_t, byte_mask(),
//             lane_align().
//  Revision : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Word-address field is sized for the widest byte address the block can be
  // built with; narrower builds leave the upper bits at zero.
  localparam int WADDR_MAX_W = 30;

  typedef struct packed {
    logic [WADDR_MAX_W-1:0] waddr;
    logic [31:0]            wdata;
    logic [3:0]             be;
  } sb_entry_t;

  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ok;
  } lane_t;

  // Returns {ok, be}. ok is low for misaligned half/word or unknown sizes.
  function automatic logic [4:0] byte_mask(input logic [1:0] addr,
                                           input logic [2:0] funct3);
    logic [3:0] be;
    logic       ok;
    be = 4'b0000;
    ok = 1'b0;
    case (funct3)
      F3_SB: begin
        be = 4'b0001 << addr;
        ok = 1'b1;
      end
      F3_SH: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        ok = ~addr[0];
      end
      F3_SW: begin
        be = 4'b1111;
        ok = (addr == 2'b00);
      end
      default: ;
    endcase
    return {ok, be};
  endfunction

  // Replicates the significant low bytes across every lane so the byte
  // enables alone select what memory actually writes.
  function automatic lane_t lane_align(input logic [1:0]  addr,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] data);
    lane_t      r;
    logic [4:0] m;
    m       = byte_mask(addr, funct3);
    r.ok    = m[4];
    r.be    = m[3:0];
    case (funct3)
      F3_SB:   r.wdata = {4{data[7:0]}};
      F3_SH:   r.wdata = {2{data[15:0]}};
      default: r.wdata = data;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sb_fifo
//  Purpose  : Generic DEPTH-entry register FIFO. All storage is exposed,
//             together with a per-slot valid mask, so a parent can search the
//             pending entries. Push while full and pop while empty are ignored.
//  Ports    : clk, reset (async, active high), push/push_data, pop,
//             full, empty, entries[DEPTH], slot_valid[DEPTH], rd_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module sb_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output T [DEPTH-1:0]               entries,
  output logic [DEPTH-1:0]           slot_valid,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == (PTR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      entries  <= '0;
    end else begin
      if (w_do_push) begin
        entries[r_wr_ptr] <= push_data;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // A slot holds a live entry when its distance from the head is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] w_offset;
    assign w_offset      = PTR_W'(i) - rd_ptr;
    assign slot_valid[i] = ({1'b0, w_offset} < r_count);
  end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Store stage in front of the data memory. Aligns SB/SH/SW data
//             into byte lanes, queues stores in order and drains them with a
//             valid/ack handshake. Flags loads overlapping any pending store.
//  Ports    : clk, reset (async, active high)
//             st_valid/st_ready/st_addr/st_data/st_funct3 - store request
//             misalign  - one-cycle pulse after a dropped (misaligned) store
//             mem_wr_en/mem_addr/mem_wdata/mem_be/mem_ack - memory write port
//             ld_valid/ld_addr/ld_funct3/ld_hazard - load overlap check
//             empty, stall_cnt
//  Options  : STORE_BUFFER_STATS_EN - enables the saturating stall_cnt
//             counter; otherwise stall_cnt is tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [2:0]        st_funct3,
  output logic              misalign,
  output logic              mem_wr_en,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_funct3,
  output logic              ld_hazard,
  output logic              empty,
  output logic [15:0]       stall_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  lane_t                  w_align;
  sb_entry_t              w_entry;
  logic                   w_accept;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  sb_entry_t [DEPTH-1:0]  w_entries;
  logic [DEPTH-1:0]       w_slot_valid;
  logic [PTR_W-1:0]       w_rd_ptr;
  logic [2:0]             w_ld_size;
  logic [4:0]             w_ld_mask_raw;
  logic [3:0]             w_ld_mask;
  logic [WADDR_MAX_W-1:0] w_ld_waddr;
  logic                   w_hit;
  logic                   r_misalign;

  // --------------------------------------------------------------------------
  // Store acceptance and alignment
  // --------------------------------------------------------------------------
  always_comb begin
    w_align                    = lane_align(st_addr[1:0], st_funct3, st_data);
    w_entry                    = '0;
    w_entry.waddr[ADDR_W-3:0]  = st_addr[ADDR_W-1:2];
    w_entry.wdata              = w_align.wdata;
    w_entry.be                 = w_align.be;
  end

  // No full-bypass: readiness depends only on the registered occupancy.
  assign st_ready = !w_full;
  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && w_align.ok;
  assign w_pop    = mem_ack && !w_empty;

  // A bad store still completes its handshake; it is simply not queued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept && !w_align.ok;
    end
  end
  assign misalign = r_misalign;

  // --------------------------------------------------------------------------
  // Entry storage
  // --------------------------------------------------------------------------
  sb_fifo #(
    .DEPTH (DEPTH),
    .T     (sb_entry_t)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (w_push),
    .push_data  (w_entry),
    .pop        (w_pop),
    .full       (w_full),
    .empty      (w_empty),
    .entries    (w_entries),
    .slot_valid (w_slot_valid),
    .rd_ptr     (w_rd_ptr)
  );

  // Memory side is driven purely from stored state.
  assign empty     = w_empty;
  assign mem_wr_en = !w_empty;
  assign mem_addr  = w_entries[w_rd_ptr].waddr[ADDR_W-3:0];
  assign mem_wdata = w_entries[w_rd_ptr].wdata;
  assign mem_be    = w_entries[w_rd_ptr].be;

  // --------------------------------------------------------------------------
  // Load overlap detection
  // --------------------------------------------------------------------------
  // Unsigned load encodings share the signed sizes; anything unrecognised or
  // misaligned conservatively covers the whole word.
  always_comb begin
    case (ld_funct3)
      F3_LBU:  w_ld_size = F3_SB;
      F3_LHU:  w_ld_size = F3_SH;
      default: w_ld_size = ld_funct3;
    endcase
    w_ld_mask_raw = byte_mask(ld_addr[1:0], w_ld_size);
    w_ld_mask     = w_ld_mask_raw[4] ? w_ld_mask_raw[3:0] : 4'b1111;
    w_ld_waddr                 = '0;
    w_ld_waddr[ADDR_W-3:0]     = ld_addr[ADDR_W-1:2];
  end

  // The head stays in the search until the edge that retires it.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_valid[i] && (w_entries[i].waddr == w_ld_waddr) &&
          ((w_entries[i].be & w_ld_mask) != 4'b0000)) begin
        w_hit = 1'b1;
      end
    end
  end
  assign ld_hazard = ld_valid && w_hit;

  // --------------------------------------------------------------------------
  // Back-pressure statistics
  // --------------------------------------------------------------------------
`ifdef STORE_BUFFER_STATS_EN
  logic [15:0] r_stall_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (st_valid && !st_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Self-checking bench for store_buffer. A byte-range reference
//             model predicts queued writes into a scoreboard queue; a monitor
//             on the falling edge compares every DUT output against it.
//             Directed scenarios are followed by a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr = '0;
  logic [31:0]       st_data = '0;
  logic [2:0]        st_funct3 = '0;
  logic              misalign;
  logic              mem_wr_en;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ack = 1'b0;
  logic              ld_valid = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [2:0]        ld_funct3 = '0;
  logic              ld_hazard;
  logic              empty;
  logic [15:0]       stall_cnt;

  always #5 clk = ~clk;

  store_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .misalign  (misalign),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_funct3 (ld_funct3),
    .ld_hazard (ld_hazard),
    .empty     (empty),
    .stall_cnt (stall_cnt)
  );

  // --------------------------------------------------------------------------
  // Reference model: each pending store is a byte range plus its memory image
  // --------------------------------------------------------------------------
  typedef struct {
    int unsigned word;
    logic [31:0] wdata;
    logic [3:0]  be;
    int unsigned baddr;
    int unsigned nbytes;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_mis = 1'b0;
  int unsigned exp_stall = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned st_size(input logic [2:0] f);
    case (f)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic exp_hazard();
    int unsigned la, ln;
    if (!ld_valid) return 1'b0;
    case (ld_funct3)
      3'd0, 3'd4: ln = 1;
      3'd1, 3'd5: ln = 2;
      3'd2:       ln = 4;
      default:    ln = 0;
    endcase
    la = ld_addr;
    if (ln == 0 || (la % ln) != 0) begin
      la = la - (la % 4);
      ln = 4;
    end
    foreach (exp_q[i]) begin
      if (exp_q[i].baddr < la + ln && la < exp_q[i].baddr + exp_q[i].nbytes)
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Predictor: applies the edge's handshakes to the model.
  always @(posedge clk or posedge reset) begin
    int unsigned n, a;
    logic        can, ok;
    exp_t        e;
    if (reset) begin
      exp_q.delete();
      exp_mis   = 1'b0;
      exp_stall = 0;
    end else begin
      can = (exp_q.size() < DEPTH);
      n   = st_size(st_funct3);
      a   = st_addr;
      ok  = (n != 0) && ((a % n) == 0);
`ifdef STORE_BUFFER_STATS_EN
      if (st_valid && !can && exp_stall < 32'hFFFF) exp_stall++;
`endif
      if (mem_ack && exp_q.size() > 0) void'(exp_q.pop_front());
      if (st_valid && can && ok) begin
        e.word   = a / 4;
        e.baddr  = a;
        e.nbytes = n;
        case (n)
          1:       e.wdata = {4{st_data[7:0]}};
          2:       e.wdata = {2{st_data[15:0]}};
          default: e.wdata = st_data;
        endcase
        for (int k = 0; k < 4; k++)
          e.be[k] = (k >= (a % 4)) && (k < (a % 4) + n);
        exp_q.push_back(e);
      end
      exp_mis = st_valid && can && !ok;
    end
  end

  // Monitor: compares every output against the model each falling edge.
  always @(negedge clk) begin
    chk("st_ready", {31'd0, st_ready}, {31'd0, exp_q.size() < DEPTH});
    chk("empty", {31'd0, empty}, {31'd0, exp_q.size() == 0});
    chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, exp_q.size() != 0});
    chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    chk("ld_hazard", {31'd0, ld_hazard}, {31'd0, exp_hazard()});
    chk("stall_cnt", {16'd0, stall_cnt}, exp_stall);
    if (mem_wr_en && exp_q.size() != 0) begin
      chk("wr_addr", {25'd0, mem_addr}, exp_q[0].word);
      chk("wr_data", mem_wdata, exp_q[0].wdata);
      chk("wr_be", {28'd0, mem_be}, {28'd0, exp_q[0].be});
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [2:0] f);
    logic acc;
    int   n;
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f;
    acc = 1'b0; n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = st_ready;
      n++;
      cyc();
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL store_timeout: got not-accepted expected accepted addr=%0h", a);
    end
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    mem_ack = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!empty && n < 50);
    mem_ack = 1'b0;
    total++;
    if (!empty) begin
      bad++;
      $display("FAIL drain_timeout: got empty=%0d expected 1", empty);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, st_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    cyc();

    // Byte store lands in lane 2 of word 1
    store(9'h006, 32'h000000A5, 3'b000);
    @(negedge clk);
    chk("sb_wr_en", {31'd0, mem_wr_en}, 32'd1);
    chk("sb_addr", {25'd0, mem_addr}, 32'h01);
    chk("sb_be", {28'd0, mem_be}, 32'h4);
    chk("sb_data", mem_wdata, 32'hA5A5A5A5);
    cyc(); mem_ack = 1'b1; cyc(); mem_ack = 1'b0;
    @(negedge clk);
    chk("sb_empty_after_ack", {31'd0, empty}, 32'd1);

    // Misaligned half is consumed and dropped
    store(9'h003, 32'h1234, 3'b001);
    @(negedge clk);
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_no_write", {31'd0, mem_wr_en}, 32'd0);
    cyc();
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, misalign}, 32'd0);
    store(9'h008, 32'hDEADBEEF, 3'b010);
    @(negedge clk);
    chk("sw_be", {28'd0, mem_be}, 32'hF);
    chk("sw_addr", {25'd0, mem_addr}, 32'h02);
    drain();

    // Fill, back-pressure, single-slot release
    for (int i = 0; i < 4; i++) store(9'(32'h20 + 4 * i), $urandom, 3'b010);
    @(negedge clk);
    chk("full_ready", {31'd0, st_ready}, 32'd0);
    st_valid = 1'b1; st_addr = 9'h030; st_data = 32'hCAFE0005; st_funct3 = 3'b010;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef STORE_BUFFER_STATS_EN
    chk("stall3", {16'd0, stall_cnt}, 32'd3);
`else
    chk("stall3", {16'd0, stall_cnt}, 32'd0);
`endif
    cyc(); mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0;
    @(negedge clk);
    chk("one_slot_free", {31'd0, st_ready}, 32'd1);
    cyc(); st_valid = 1'b0;
    @(negedge clk);
    chk("refull_ready", {31'd0, st_ready}, 32'd0);
    drain();

    // Push and pop together at count 1
    store(9'h040, 32'h11111111, 3'b010);
    st_valid = 1'b1; st_addr = 9'h044; st_data = 32'h22222222; st_funct3 = 3'b010;
    mem_ack = 1'b1;
    cyc(); st_valid = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    chk("pp_not_empty", {31'd0, empty}, 32'd0);
    chk("pp_new_head", {25'd0, mem_addr}, 32'h11);
    drain();

    // Load overlap checks
    store(9'h011, 32'h0000005A, 3'b000);
    ld_valid = 1'b1; ld_addr = 9'h011; ld_funct3 = 3'b000;
    @(negedge clk);
    chk("haz_lb_hit", {31'd0, ld_hazard}, 32'd1);
    ld_addr = 9'h010; #1;
    chk("haz_lb_miss", {31'd0, ld_hazard}, 32'd0);
    ld_funct3 = 3'b010; #1;
    chk("haz_lw_hit", {31'd0, ld_hazard}, 32'd1);
    cyc(); mem_ack = 1'b1;
    @(negedge clk);
    chk("haz_until_ack", {31'd0, ld_hazard}, 32'd1);
    cyc(); mem_ack = 1'b0;
    @(negedge clk);
    chk("haz_after_ack", {31'd0, ld_hazard}, 32'd0);
    ld_valid = 1'b0;
    cyc();

    // Asynchronous reset discards pending stores
    for (int i = 0; i < 3; i++) store(9'(32'h080 + 4 * i), $urandom, 3'b010);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("arst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    cyc(); reset = 1'b0; mem_ack = 1'b1;
    repeat (4) cyc();
    mem_ack = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      cyc();
      st_valid  = ($urandom % 3) != 0;
      st_addr   = 9'($urandom_range(0, 31));
      st_data   = $urandom;
      case ($urandom % 10)
        0, 1, 2: f = 3'b000;
        3, 4, 5: f = 3'b001;
        6, 7, 8: f = 3'b010;
        default: f = 3'($urandom);
      endcase
      st_funct3 = f;
      mem_ack   = ($urandom % 3) == 0;
      ld_valid  = ($urandom % 2) != 0;
      ld_addr   = 9'($urandom_range(0, 31));
      ld_funct3 = 3'($urandom);
    end
    cyc();
    st_valid = 1'b0; ld_valid = 1'b0;
    drain();
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
